// File: rtl/addr_mgmt.sv
// rtl/addr_mgmt.sv - block-granular packet RAM address manager for data_ctrl
// Purpose: splits the packet RAM into fixed blocks, hands a free block base to the
//   write side, queues finished packets in arrival order, launches reads when the
//   scheduler is ready and recycles a block once its read completes.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_pkt_data[133:0]         snooped packet line, [133:132] 01=SOP 11=mid 10=EOP
//   in_pkt_data_wr             line valid
//   out_alloc_ready            a free block is held in addr2data_waddr
//   addr2data_waddr[10:0]      write base address, addr2data_waddr_wr pulses on load
//   in_sched_ready             downstream can accept a packet
//   addr2data_raddr[10:0]      read base address, addr2data_raddr_wr launches the read
//   out_data_cache_valid_wr    data_ctrl finished reading the in-flight packet
//   out_pkt_cnt[6:0]           packets queued but not yet launched
//   out_err_ovf                pulse: packet longer than a block, or SOP while busy
module addr_mgmt #(
  parameter int BLK_W  = 6,
  parameter int LINE_W = 5,
  parameter int ADDR_W = BLK_W + LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [133:0]      in_pkt_data,
  input  logic              in_pkt_data_wr,
  output logic              out_alloc_ready,
  output logic [ADDR_W-1:0] addr2data_waddr,
  output logic              addr2data_waddr_wr,
  input  logic              in_sched_ready,
  output logic [ADDR_W-1:0] addr2data_raddr,
  output logic              addr2data_raddr_wr,
  input  logic              out_data_cache_valid_wr,
  output logic [BLK_W:0]    out_pkt_cnt,
  output logic              out_err_ovf
);

  localparam int BLK_NUM   = 1 << BLK_W;
  localparam int BLK_LINES = 1 << LINE_W;
  localparam logic [LINE_W:0] LINE_LIMIT = BLK_LINES[LINE_W:0];
  localparam logic [BLK_W-1:0] LAST_IDX  = BLK_W'(BLK_NUM - 1);

  typedef enum logic [1:0] {W_INIT, W_FETCH, W_READY, W_BUSY} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_LAUNCH, R_WAIT_DONE} rstate_e;

  wstate_e          wstate_q;
  rstate_e          rstate_q;
  logic [BLK_W-1:0] init_idx_q;
  logic [BLK_W-1:0] wblk_q;
  logic [BLK_W-1:0] rblk_q;
  logic [LINE_W:0]  line_cnt_q;

  logic [BLK_W-1:0] free_mem [BLK_NUM];
  logic [BLK_W-1:0] free_wptr_q, free_rptr_q;
  logic [BLK_W:0]   free_cnt_q;
  logic [BLK_W-1:0] pkt_mem [BLK_NUM];
  logic [BLK_W-1:0] pkt_wptr_q, pkt_rptr_q;
  logic [BLK_W:0]   pkt_cnt_q;

  logic             free_push, free_pop, pkt_push, pkt_pop;
  logic [BLK_W-1:0] free_push_idx;
  logic             line_sop, line_eop;
  logic             unused_payload;

  assign line_sop       = in_pkt_data_wr && (in_pkt_data[133:132] == 2'b01);
  assign line_eop       = in_pkt_data_wr && (in_pkt_data[133:132] == 2'b10);
  assign unused_payload = ^in_pkt_data[131:0];
  assign out_pkt_cnt    = pkt_cnt_q;

  // INIT seeding and read completion never overlap: the packet queue is empty
  // during INIT, so no read can be in flight.
  always_comb begin
    free_push     = 1'b0;
    free_push_idx = '0;
    if (wstate_q == W_INIT) begin
      free_push     = 1'b1;
      free_push_idx = init_idx_q;
    end else if (rstate_q == R_WAIT_DONE && out_data_cache_valid_wr) begin
      free_push     = 1'b1;
      free_push_idx = rblk_q;
    end
    free_pop = (wstate_q == W_FETCH) && (free_cnt_q != '0);
    pkt_push = (wstate_q == W_BUSY) && line_eop;
    pkt_pop  = (rstate_q == R_IDLE) && (pkt_cnt_q != '0) && in_sched_ready;
  end

  always_ff @(posedge clk) begin
    if (free_push) free_mem[free_wptr_q] <= free_push_idx;
    if (pkt_push)  pkt_mem[pkt_wptr_q]   <= wblk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_wptr_q <= '0;
      free_rptr_q <= '0;
      free_cnt_q  <= '0;
      pkt_wptr_q  <= '0;
      pkt_rptr_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      if (free_push) free_wptr_q <= free_wptr_q + 1'b1;
      if (free_pop)  free_rptr_q <= free_rptr_q + 1'b1;
      if (free_push && !free_pop)      free_cnt_q <= free_cnt_q + 1'b1;
      else if (!free_push && free_pop) free_cnt_q <= free_cnt_q - 1'b1;
      if (pkt_push) pkt_wptr_q <= pkt_wptr_q + 1'b1;
      if (pkt_pop)  pkt_rptr_q <= pkt_rptr_q + 1'b1;
      if (pkt_push && !pkt_pop)      pkt_cnt_q <= pkt_cnt_q + 1'b1;
      else if (!pkt_push && pkt_pop) pkt_cnt_q <= pkt_cnt_q - 1'b1;
    end
  end

  // Write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q           <= W_INIT;
      init_idx_q         <= '0;
      wblk_q             <= '0;
      line_cnt_q         <= '0;
      out_alloc_ready    <= 1'b0;
      addr2data_waddr    <= '0;
      addr2data_waddr_wr <= 1'b0;
      out_err_ovf        <= 1'b0;
    end else begin
      addr2data_waddr_wr <= 1'b0;
      out_err_ovf        <= 1'b0;
      case (wstate_q)
        W_INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == LAST_IDX) wstate_q <= W_FETCH;
        end
        W_FETCH: begin
          if (free_cnt_q != '0) begin
            wblk_q             <= free_mem[free_rptr_q];
            addr2data_waddr    <= {free_mem[free_rptr_q], {LINE_W{1'b0}}};
            addr2data_waddr_wr <= 1'b1;
            out_alloc_ready    <= 1'b1;
            wstate_q           <= W_READY;
          end
        end
        W_READY: begin
          if (line_sop) begin
            out_alloc_ready <= 1'b0;
            line_cnt_q      <= 1;
            wstate_q        <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (in_pkt_data_wr) begin
            // Saturating, so the block-full crossing is seen once per packet.
            if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + 1'b1;
            if (line_cnt_q == LINE_LIMIT || line_sop) out_err_ovf <= 1'b1;
            if (line_eop) wstate_q <= W_FETCH;
          end
        end
        default: wstate_q <= W_INIT;
      endcase
    end
  end

  // Read FSM: one packet in flight at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q           <= R_IDLE;
      rblk_q             <= '0;
      addr2data_raddr    <= '0;
      addr2data_raddr_wr <= 1'b0;
    end else begin
      addr2data_raddr_wr <= 1'b0;
      case (rstate_q)
        R_IDLE: begin
          if (pkt_pop) begin
            rblk_q   <= pkt_mem[pkt_rptr_q];
            rstate_q <= R_LAUNCH;
          end
        end
        R_LAUNCH: begin
          addr2data_raddr    <= {rblk_q, {LINE_W{1'b0}}};
          addr2data_raddr_wr <= 1'b1;
          rstate_q           <= R_WAIT_DONE;
        end
        R_WAIT_DONE: begin
          if (out_data_cache_valid_wr) rstate_q <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_mgmt.sv
// tb/tb_addr_mgmt.sv - directed self-checking bench for addr_mgmt
module tb_addr_mgmt;
  localparam logic [1:0] SOP = 2'b01, MID = 2'b11, EOP = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [133:0] in_pkt_data;
  logic         in_pkt_data_wr;
  logic         out_alloc_ready;
  logic [10:0]  addr2data_waddr;
  logic         addr2data_waddr_wr;
  logic         in_sched_ready;
  logic [10:0]  addr2data_raddr;
  logic         addr2data_raddr_wr;
  logic         out_data_cache_valid_wr;
  logic [6:0]   out_pkt_cnt;
  logic         out_err_ovf;

  addr_mgmt dut (
    .clk(clk), .rst_n(rst_n),
    .in_pkt_data(in_pkt_data), .in_pkt_data_wr(in_pkt_data_wr),
    .out_alloc_ready(out_alloc_ready),
    .addr2data_waddr(addr2data_waddr), .addr2data_waddr_wr(addr2data_waddr_wr),
    .in_sched_ready(in_sched_ready),
    .addr2data_raddr(addr2data_raddr), .addr2data_raddr_wr(addr2data_raddr_wr),
    .out_data_cache_valid_wr(out_data_cache_valid_wr),
    .out_pkt_cnt(out_pkt_cnt), .out_err_ovf(out_err_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ovf_pulses = 0;
  int rd_pulses = 0;
  logic [5:0] free_m[$];
  logic [5:0] pkt_m[$];
  logic [5:0] cur_blk;
  bit         held;

  always @(negedge clk) begin
    if (out_err_ovf === 1'b1) ovf_pulses++;
    if (addr2data_raddr_wr === 1'b1) rd_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    free_m.delete();
    for (int i = 0; i < 64; i++) free_m.push_back(6'(i));
    pkt_m.delete();
    held = 1'b0;
  endtask

  task automatic drive_line(input logic [1:0] code);
    in_pkt_data    = {code, 100'h0, $urandom()};
    in_pkt_data_wr = 1'b1;
    step();
    in_pkt_data_wr = 1'b0;
  endtask

  task automatic next_alloc(input string name);
    int n = 0;
    if (!held) begin
      while (out_alloc_ready !== 1'b1 && n < 200) begin step(); n++; end
      checks++;
      if (out_alloc_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_alloc_timeout got=%b exp=1", name, out_alloc_ready);
      end
      cur_blk = free_m.pop_front();
      held = 1'b1;
    end
    checks++;
    if (addr2data_waddr !== {cur_blk, 5'b0}) begin
      failures++;
      $display("FAIL %s_waddr got=%h exp=%h", name, addr2data_waddr, {cur_blk, 5'b0});
    end
  endtask

  task automatic send_pkt(input int n);
    held = 1'b0;
    for (int i = 1; i <= n; i++) drive_line(i == 1 ? SOP : (i == n ? EOP : MID));
    pkt_m.push_back(cur_blk);
  endtask

  task automatic read_one(input string name);
    int n = 0;
    logic [5:0] exp;
    while (addr2data_raddr_wr !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (addr2data_raddr_wr !== 1'b1) begin
      failures++;
      $display("FAIL %s_raddr_wr_timeout got=%b exp=1", name, addr2data_raddr_wr);
    end
    exp = pkt_m.pop_front();
    checks++;
    if (addr2data_raddr !== {exp, 5'b0}) begin
      failures++;
      $display("FAIL %s_raddr got=%h exp=%h", name, addr2data_raddr, {exp, 5'b0});
    end
    out_data_cache_valid_wr = 1'b1;
    step();
    out_data_cache_valid_wr = 1'b0;
    free_m.push_back(exp);
  endtask

  task automatic check_init(input string name);
    int early = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (out_alloc_ready !== 1'b0 || addr2data_waddr_wr !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL %s_init_alloc_early got=%0d exp=0", name, early);
    end
    step();
    checks++;
    if ({addr2data_waddr_wr, out_alloc_ready, addr2data_waddr} !== {2'b11, 11'h000}) begin
      failures++;
      $display("FAIL %s_first_alloc got=%b%b/%h exp=11/000", name,
               addr2data_waddr_wr, out_alloc_ready, addr2data_waddr);
    end
    step();
    checks++;
    if (addr2data_waddr_wr !== 1'b0) begin
      failures++;
      $display("FAIL %s_waddr_wr_pulse got=%b exp=0", name, addr2data_waddr_wr);
    end
  endtask

  task automatic test_reset();
    logic [32:0] outs;
    model_reset();
    rst_n = 1'b0;
    in_pkt_data = '0;
    in_pkt_data_wr = 1'b0;
    in_sched_ready = 1'b0;
    out_data_cache_valid_wr = 1'b0;
    repeat (3) step();
    outs = {out_alloc_ready, addr2data_waddr, addr2data_waddr_wr, addr2data_raddr,
            addr2data_raddr_wr, out_pkt_cnt, out_err_ovf};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    rst_n = 1'b1;
    check_init("reset");
  endtask

  task automatic test_single_pkt();
    in_sched_ready = 1'b1;
    next_alloc("single");
    held = 1'b0;
    drive_line(SOP);
    checks++;
    if (out_alloc_ready !== 1'b0 || out_pkt_cnt !== 7'd0) begin
      failures++;
      $display("FAIL single_after_sop got=%b/%0d exp=0/0", out_alloc_ready, out_pkt_cnt);
    end
    drive_line(MID);
    drive_line(MID);
    drive_line(EOP);
    checks++;
    if (out_pkt_cnt !== 7'd1) begin
      failures++;
      $display("FAIL single_pkt_cnt got=%0d exp=1", out_pkt_cnt);
    end
    step();
    checks++;
    if ({addr2data_waddr_wr, out_alloc_ready, addr2data_waddr, out_pkt_cnt} !== {2'b11, 11'h020, 7'd0}) begin
      failures++;
      $display("FAIL single_next_alloc got=%b%b/%h/%0d exp=11/020/0", addr2data_waddr_wr,
               out_alloc_ready, addr2data_waddr, out_pkt_cnt);
    end
    step();
    checks++;
    if (addr2data_raddr_wr !== 1'b1 || addr2data_raddr !== 11'h000) begin
      failures++;
      $display("FAIL single_raddr got=%b/%h exp=1/000", addr2data_raddr_wr, addr2data_raddr);
    end
    out_data_cache_valid_wr = 1'b1;
    step();
    out_data_cache_valid_wr = 1'b0;
    checks++;
    if (addr2data_raddr_wr !== 1'b0) begin
      failures++;
      $display("FAIL single_raddr_wr_pulse got=%b exp=0", addr2data_raddr_wr);
    end
    free_m.push_back(6'd0);
  endtask

  task automatic test_wrap();
    in_sched_ready = 1'b1;
    for (int i = 0; i < 63; i++) begin
      next_alloc("wrap");
      send_pkt(2);
      read_one("wrap");
    end
    next_alloc("wrap_final");
    checks++;
    if (addr2data_waddr !== 11'h000 || rd_pulses != 64) begin
      failures++;
      $display("FAIL wrap_waddr got=%h/%0d exp=000/64", addr2data_waddr, rd_pulses);
    end
  endtask

  task automatic test_back_to_back();
    in_sched_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      next_alloc("bp");
      send_pkt(2);
    end
    repeat (10) step();
    checks++;
    if (out_alloc_ready !== 1'b0 || out_pkt_cnt !== 7'd64) begin
      failures++;
      $display("FAIL bp_full got=%b/%0d exp=0/64", out_alloc_ready, out_pkt_cnt);
    end
    in_sched_ready = 1'b1;
    step();
    in_sched_ready = 1'b0;
    checks++;
    if (out_pkt_cnt !== 7'd63) begin
      failures++;
      $display("FAIL bp_pop_cnt got=%0d exp=63", out_pkt_cnt);
    end
    read_one("bp_first");
    next_alloc("bp_realloc");
    checks++;
    if (addr2data_waddr !== 11'h000) begin
      failures++;
      $display("FAIL bp_realloc_addr got=%h exp=000", addr2data_waddr);
    end
    in_sched_ready = 1'b1;
    for (int i = 0; i < 63; i++) read_one("bp_drain");
    repeat (3) step();
    checks++;
    if (out_pkt_cnt !== 7'd0) begin
      failures++;
      $display("FAIL bp_drained_cnt got=%0d exp=0", out_pkt_cnt);
    end
  endtask

  task automatic test_overflow();
    int ovf0;
    in_sched_ready = 1'b0;
    next_alloc("ovf");
    held = 1'b0;
    ovf0 = ovf_pulses;
    for (int i = 1; i <= 40; i++) begin
      drive_line(i == 1 ? SOP : (i == 40 ? EOP : MID));
      if (i == 32 || i == 33 || i == 34) begin
        checks++;
        if (out_err_ovf !== (i == 33)) begin
          failures++;
          $display("FAIL ovf_line%0d got=%b exp=%b", i, out_err_ovf, i == 33);
        end
      end
    end
    pkt_m.push_back(cur_blk);
    checks++;
    if (out_pkt_cnt !== 7'd1) begin
      failures++;
      $display("FAIL ovf_pkt_cnt got=%0d exp=1", out_pkt_cnt);
    end
    step();
    checks++;
    if (ovf_pulses - ovf0 != 1) begin
      failures++;
      $display("FAIL ovf_pulse_count got=%0d exp=1", ovf_pulses - ovf0);
    end
    in_sched_ready = 1'b1;
    read_one("ovf");
  endtask

  task automatic test_sop_busy();
    int ovf0;
    next_alloc("sopbusy");
    held = 1'b0;
    ovf0 = ovf_pulses;
    drive_line(SOP);
    drive_line(MID);
    checks++;
    if (out_err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL sopbusy_mid got=%b exp=0", out_err_ovf);
    end
    drive_line(SOP);
    checks++;
    if (out_err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL sopbusy_sop got=%b exp=1", out_err_ovf);
    end
    drive_line(EOP);
    pkt_m.push_back(cur_blk);
    read_one("sopbusy");
    checks++;
    if (ovf_pulses - ovf0 != 1) begin
      failures++;
      $display("FAIL sopbusy_pulse_count got=%0d exp=1", ovf_pulses - ovf0);
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] outs;
    int n = 0;
    int rd0;
    in_sched_ready = 1'b1;
    next_alloc("rstmid");
    send_pkt(4);
    while (addr2data_raddr_wr !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (addr2data_raddr_wr !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_read_start got=%b exp=1", addr2data_raddr_wr);
    end
    next_alloc("rstmid_second");
    in_pkt_data = {SOP, 132'h5};
    in_pkt_data_wr = 1'b1;
    step();
    in_pkt_data = {MID, 132'h6};
    step();
    rst_n = 1'b0;
    in_pkt_data_wr = 1'b0;
    #2;
    outs = {out_alloc_ready, addr2data_waddr, addr2data_waddr_wr, addr2data_raddr,
            addr2data_raddr_wr, out_pkt_cnt, out_err_ovf};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h exp=0", outs);
    end
    rd0 = rd_pulses;
    repeat (3) step();
    rst_n = 1'b1;
    model_reset();
    check_init("rstmid");
    repeat (5) step();
    checks++;
    if (rd_pulses != rd0 || out_pkt_cnt !== 7'd0) begin
      failures++;
      $display("FAIL rstmid_no_read got=%0d/%0d exp=%0d/0", rd_pulses, out_pkt_cnt, rd0);
    end
    next_alloc("rstmid_after");
    send_pkt(3);
    read_one("rstmid_after");
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_wrap();
    test_back_to_back();
    test_overflow();
    test_sop_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
